// File: rtl/rom_sweep_reader.sv
// Parallel ROM reader: manual up/down stepping or automatic 0..end sweep,
// settle-then-sample timing, valid/ready output and a running modular checksum.
module rom_sweep_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 11,
    parameter int SETTLE_CYCLES  = 4,
    parameter int CHECKSUM_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      increment_address,
    input  logic                      decrement_address,
    input  logic                      start_sweep,
    input  logic [ADDRESS_WIDTH-1:0]  end_address,
    input  logic [DATA_WIDTH-1:0]     data_line_in,
    input  logic                      data_ready,
    output logic [ADDRESS_WIDTH-1:0]  address_line,
    output logic                      chip_select_n,
    output logic [DATA_WIDTH-1:0]     data_line,
    output logic                      data_valid,
    output logic [CHECKSUM_WIDTH-1:0] checksum,
    output logic [3:0]                operation,
    output logic                      busy,
    output logic                      sweep_done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Handshake: a word transfers on every rising edge where data_valid and
    // data_ready are both high; data_line is held stable until then.

    // Bits [1:0] form the synchroniser, bit [2] remembers the previous level.
    logic [2:0] inc_sync_q, dec_sync_q, start_sync_q;
    logic       inc_edge, dec_edge, start_edge;

    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0]  end_q, end_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      valid_q, valid_d;
    logic [CHECKSUM_WIDTH-1:0] sum_q, sum_d;
    logic                      sweep_q, sweep_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_sync_q   <= '0;
            dec_sync_q   <= '0;
            start_sync_q <= '0;
        end else begin
            inc_sync_q   <= {inc_sync_q[1:0], increment_address};
            dec_sync_q   <= {dec_sync_q[1:0], decrement_address};
            start_sync_q <= {start_sync_q[1:0], start_sweep};
        end
    end

    assign inc_edge   = inc_sync_q[1] & ~inc_sync_q[2];
    assign dec_edge   = dec_sync_q[1] & ~dec_sync_q[2];
    assign start_edge = start_sync_q[1] & ~start_sync_q[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        end_d   = end_q;
        data_d  = data_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    addr_d  = '0;
                    sum_d   = '0;
                    end_d   = end_address;
                    sweep_d = 1'b1;
                    state_d = ST_SETTLE;
                end else if (inc_edge && !dec_edge) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_SETTLE;
                end else if (dec_edge && !inc_edge) begin
                    addr_d  = addr_q - 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                data_d  = data_line_in;
                valid_d = 1'b1;
                sum_d   = sum_q + CHECKSUM_WIDTH'(data_line_in);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (data_ready) begin
                    valid_d = 1'b0;
                    if (!sweep_q) begin
                        state_d = ST_IDLE;
                    end else if (addr_q != end_q) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                sweep_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            end_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            sweep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            sweep_q <= sweep_d;
        end
    end

    // The ROM is only enabled while the address is settling or being sampled.
    assign chip_select_n = !(state_q == ST_SETTLE || state_q == ST_SAMPLE);
    assign address_line  = addr_q;
    assign data_line     = data_q;
    assign data_valid    = valid_q;
    assign checksum      = sum_q;
    assign operation     = {1'b0, state_q};
    assign busy          = (state_q != ST_IDLE);
    assign sweep_done    = (state_q == ST_DONE);

endmodule

// File: doc/rom_sweep_reader.md
# rom_sweep_reader

Parametrised successor to the manual-step ROM reader. It drives the address bus of a parallel ROM/PROM (556PT4-class and wider), waits a configurable settle time, and samples the data bus. Results go out over a valid/ready handshake with a running checksum. It supports both manual up/down stepping and an automatic sweep from address 0 to a programmable end address. It sits between the front-panel/button logic and the dump transmitter.

## Interface
- DATA_WIDTH, 8, ROM data bus width (4 for 556PT4).
- ADDRESS_WIDTH, 11, ROM address bus width (8 for 556PT4).
- SETTLE_CYCLES, 4, clk cycles chip_select_n is held low before sampling; must be ≥1.
- CHECKSUM_WIDTH, 16, checksum accumulator width; must be ≥ DATA_WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- increment_address  in  1  manual step up, asynchronous level; rising edge acts.
- decrement_address  in  1  manual step down, asynchronous level; rising edge acts.
- start_sweep  in  1  asynchronous level; rising edge starts an automatic sweep.
- end_address  in  ADDRESS_WIDTH  last sweep address; captured at sweep start.
- data_line_in  in  DATA_WIDTH  ROM data bus.
- data_ready  in  1  consumer accepts data_line.
- address_line  out  ADDRESS_WIDTH  ROM address.
- chip_select_n  out  1  ROM chip select, active low.
- data_line  out  DATA_WIDTH  last sampled word.
- data_valid  out  1  data_line holds an unaccepted sample.
- checksum  out  CHECKSUM_WIDTH  modular sum of words sampled in the current or last sweep.
- operation  out  4  state code.
- busy  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse when a sweep completes.

## Operation
- Each of increment_address, decrement_address and start_sweep passes through a 2-flop synchroniser plus one edge-detect flop.
- Edge = synchronised high AND previous low.
- States and their operation codes:
  - IDLE = 0
  - SETTLE = 1
  - SAMPLE = 2
  - HOLD = 3
  - DONE = 4
- IDLE:
  - A start edge sets address_line←0, checksum←0, captures end_address, sets the sweep flag, and moves to SETTLE.
  - Otherwise, an increment edge alone sets address_line+1 (wraps 2^AW−1→0) and moves to SETTLE.
  - Otherwise, a decrement edge alone sets address_line−1 (wraps 0→2^AW−1) and moves to SETTLE.
  - Increment and decrement edges in the same cycle: both ignored, stay in IDLE.
  - Start takes priority over either step edge.
- SETTLE:
  - chip_select_n=0.
  - Lasts exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE:
  - chip_select_n=0, one cycle.
  - On exit: data_line←data_line_in, data_valid←1, and checksum←checksum + zero-extended data_line_in (mod 2^CHECKSUM_WIDTH).
  - The checksum is also accumulated on manual reads.
  - Moves to HOLD.
- HOLD:
  - chip_select_n=1. data_line and address_line stay stable while data_valid=1 and data_ready=0.
  - On data_ready=1: data_valid←0, then:
    - manual read → IDLE;
    - sweep with address_line ≠ captured end → address_line+1, SETTLE;
    - sweep with address_line = captured end → DONE.
- DONE:
  - sweep_done=1 for one cycle, sweep flag cleared, then IDLE.
  - checksum holds until the next sweep start.
- Edges arriving outside IDLE are discarded; they are not queued.
- Changes on end_address after sweep start have no effect.
- Captured end = 0 produces a single-word sweep.

## Timing
- Reset values (asynchronous, applied immediately, including mid-sweep):
  - address_line=0, data_line=0, data_valid=0, chip_select_n=1
  - checksum=0, operation=0, busy=0, sweep_done=0
  - synchroniser flops=0, state IDLE
- Input latency: with an input high before rising edge E0, the edge is seen after E1 and the FSM leaves IDLE at E2.
- Per word, with data_ready held 1: SETTLE_CYCLES + 2 cycles (SETTLE, SAMPLE, HOLD).
- A full sweep of N words takes N·(SETTLE_CYCLES+2) + 1 cycles from the first SETTLE to the return to IDLE.
- data_valid rises on the edge leaving SAMPLE.
- The handshake completes on the first rising edge where data_valid=1 and data_ready=1. data_valid falls on that edge.
- address_line changes only on the IDLE→SETTLE or HOLD→SETTLE edge. It is never changed while chip_select_n=0.

## Test plan
- Reset: hold reset_n=0 mid-SETTLE of a sweep → all outputs at reset values within the same cycle; after release, FSM stays in IDLE with no spurious step.
- Manual step (DW=4, AW=8, SETTLE=4), data_line_in=4'hB, one increment pulse → address_line=1, chip_select_n low for 5 cycles, data_line=4'hB, one data_valid accept, checksum=11, back to IDLE.
- Wrap-around: from address 0, one decrement pulse → address_line=8'hFF. Then one increment pulse → address_line=0. Simultaneous increment+decrement pulses → no change, operation stays 0.
- Sweep, data_ready=1: end_address=3, data_line_in model returns address+5 → words 5,6,7,8 delivered in order, checksum=26, sweep_done pulses once, total 4·6+1 cycles.
- Backpressure: hold data_ready=0 for 10 cycles at address 2 → data_line, address_line and data_valid stay frozen and chip_select_n=1. Release → sweep resumes with no word lost or duplicated.
- Checksum wrap (DW=8, CHECKSUM_WIDTH=8): sweep 0..1 reading 8'hFF, 8'h02 → checksum=8'h01. A start pulse issued mid-sweep is ignored.
